// File: rtl/pipe_latch_stage.sv
// -----------------------------------------------------------------------------
// pipe_latch_stage
//
// Generic pipeline register stage for one boundary between pipeline stages
// (IF/ID, ID/EX, EX/MEM or MEM/WB). It carries a payload and a control field
// and uses a valid/ready handshake on both sides.
//
// Parameters
//   DW    payload width; the instantiating stage packs its own fields into it
//   CW    control width; zeroed on reset and flush, masked while not valid
//   SKID  1: main + skid entry, in_ready comes straight from a flop
//         0: single entry, in_ready is combinational from out_ready
//   CNTW  width of the saturating bubble counter
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous active-high reset
//   in_valid    upstream entry present
//   in_ready    stage accepts an entry this cycle
//   in_data     upstream payload
//   in_ctrl     upstream control bits
//   flush       kill every entry held in the stage (takes effect next cycle)
//   out_valid   out_data/out_ctrl carry a live entry
//   out_ready   downstream accepts
//   out_data    payload to the next stage
//   out_ctrl    control to the next stage, all-zero whenever out_valid=0
//   bubble_cnt  cycles in which downstream was ready but starved (saturates)
// -----------------------------------------------------------------------------
module pipe_latch_stage #(
    parameter int DW   = 32,
    parameter int CW   = 17,
    parameter int SKID = 1,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [CW-1:0]   in_ctrl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [CW-1:0]   out_ctrl,
    output logic [CNTW-1:0] bubble_cnt
);

    // Main entry: this is what the downstream stage sees.
    logic          main_valid_reg;
    logic [DW-1:0] main_data_reg;
    logic [CW-1:0] main_ctrl_reg;

    logic [CNTW-1:0] bubble_cnt_reg;

    logic in_xfer;
    assign in_xfer = in_valid & in_ready;

    generate
        if (SKID != 0) begin : g_skid
            // Second entry that absorbs the one item accepted while the main
            // entry is stalled. Because in_ready depends only on this flop and
            // flush, there is no combinational path from out_ready to in_ready.
            logic          skid_valid_reg;
            logic [DW-1:0] skid_data_reg;
            logic [CW-1:0] skid_ctrl_reg;

            assign in_ready = !skid_valid_reg & !flush;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    main_valid_reg <= 1'b0;
                    main_data_reg  <= '0;
                    main_ctrl_reg  <= '0;
                    skid_valid_reg <= 1'b0;
                    skid_data_reg  <= '0;
                    skid_ctrl_reg  <= '0;
                end else if (flush) begin
                    // Data registers keep their stale contents; only the
                    // valid bits and control fields are cleared.
                    main_valid_reg <= 1'b0;
                    main_ctrl_reg  <= '0;
                    skid_valid_reg <= 1'b0;
                    skid_ctrl_reg  <= '0;
                end else if (main_valid_reg && !out_ready) begin
                    // Main is stalled: a new entry can only park in skid.
                    if (in_xfer) begin
                        skid_valid_reg <= 1'b1;
                        skid_data_reg  <= in_data;
                        skid_ctrl_reg  <= in_ctrl;
                    end
                end else if (skid_valid_reg) begin
                    // Main is empty or draining: the older skid entry moves
                    // up first. in_ready was low, so nothing arrives now.
                    main_valid_reg <= 1'b1;
                    main_data_reg  <= skid_data_reg;
                    main_ctrl_reg  <= skid_ctrl_reg;
                    skid_valid_reg <= 1'b0;
                    skid_ctrl_reg  <= '0;
                end else if (in_xfer) begin
                    main_valid_reg <= 1'b1;
                    main_data_reg  <= in_data;
                    main_ctrl_reg  <= in_ctrl;
                end else begin
                    main_valid_reg <= 1'b0;
                end
            end
        end else begin : g_direct
            logic out_xfer;
            assign out_xfer = main_valid_reg & out_ready;

            assign in_ready = (!main_valid_reg | out_ready) & !flush;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    main_valid_reg <= 1'b0;
                    main_data_reg  <= '0;
                    main_ctrl_reg  <= '0;
                end else if (flush) begin
                    main_valid_reg <= 1'b0;
                    main_ctrl_reg  <= '0;
                end else if (in_xfer) begin
                    main_valid_reg <= 1'b1;
                    main_data_reg  <= in_data;
                    main_ctrl_reg  <= in_ctrl;
                end else if (out_xfer) begin
                    main_valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    // Starved cycle: downstream ready but nothing to give it. Saturates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bubble_cnt_reg <= '0;
        end else if (out_ready && !main_valid_reg && (bubble_cnt_reg != {CNTW{1'b1}})) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNTW'(1);
        end
    end

    assign out_valid  = main_valid_reg;
    assign out_data   = main_data_reg;
    // Masking keeps a bubble looking like a NOP even though main_ctrl_reg
    // is not cleared on an ordinary drain.
    assign out_ctrl   = main_valid_reg ? main_ctrl_reg : '0;
    assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_pipe_latch_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_latch_stage
//
// Drives two instances: dut_a (SKID=0, CNTW=16) and dut_b (SKID=1, CNTW=4).
// Each has a scoreboard queue: accepted entries are pushed, emitted entries
// are popped and compared. Directed checks cover reset, backpressure, flush,
// streaming, counter saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pipe_latch_stage;

    localparam int DW = 32;
    localparam int CW = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut_a signals
    logic          iv_a, ir_a, fl_a, ov_a, ordy_a;
    logic [DW-1:0] id_a, od_a;
    logic [CW-1:0] ic_a, oc_a;
    logic [15:0]   bc_a;

    // dut_b signals
    logic          iv_b, ir_b, fl_b, ov_b, ordy_b;
    logic [DW-1:0] id_b, od_b;
    logic [CW-1:0] ic_b, oc_b;
    logic [3:0]    bc_b;

    pipe_latch_stage #(.DW(DW), .CW(CW), .SKID(0), .CNTW(16)) dut_a (
        .CLK(clk), .RST(rst),
        .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a), .in_ctrl(ic_a),
        .flush(fl_a),
        .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a), .out_ctrl(oc_a),
        .bubble_cnt(bc_a)
    );

    pipe_latch_stage #(.DW(DW), .CW(CW), .SKID(1), .CNTW(4)) dut_b (
        .CLK(clk), .RST(rst),
        .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b), .in_ctrl(ic_b),
        .flush(fl_b),
        .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b), .out_ctrl(oc_b),
        .bubble_cnt(bc_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboards: {ctrl, data}
    logic [CW+DW-1:0] q_a[$];
    logic [CW+DW-1:0] q_b[$];
    int pops_b = 0;

    always @(negedge clk) begin
        logic [CW+DW-1:0] e;
        if (rst) begin
            q_a.delete();
        end else begin
            if (ov_a && ordy_a) begin
                if (q_a.size() == 0) begin
                    check_val("a_spurious_out", 64'(od_a), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = q_a.pop_front();
                    check_val("a_out_data", 64'(od_a), 64'(e[DW-1:0]));
                    check_val("a_out_ctrl", 64'(oc_a), 64'(e[CW+DW-1:DW]));
                    $display("a: out data=0x%0h ctrl=0x%0h", od_a, oc_a);
                end
            end
            if (!ov_a) check_val("a_nop_ctrl", 64'(oc_a), 64'd0);
            if (fl_a) q_a.delete();
            else if (iv_a && ir_a) q_a.push_back({ic_a, id_a});
        end
    end

    always @(negedge clk) begin
        logic [CW+DW-1:0] e;
        if (rst) begin
            q_b.delete();
        end else begin
            if (ov_b && ordy_b) begin
                if (q_b.size() == 0) begin
                    check_val("b_spurious_out", 64'(od_b), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = q_b.pop_front();
                    pops_b++;
                    check_val("b_out_data", 64'(od_b), 64'(e[DW-1:0]));
                    check_val("b_out_ctrl", 64'(oc_b), 64'(e[CW+DW-1:DW]));
                    $display("b: out data=0x%0h ctrl=0x%0h", od_b, oc_b);
                end
            end
            if (!ov_b) check_val("b_nop_ctrl", 64'(oc_b), 64'd0);
            if (fl_b) q_b.delete();
            else if (iv_b && ir_b) q_b.push_back({ic_b, id_b});
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gaps;
        int pops0;

        rst = 1'b1;
        iv_a = 0; id_a = '0; ic_a = '0; fl_a = 0; ordy_a = 0;
        iv_b = 0; id_b = '0; ic_b = '0; fl_b = 0; ordy_b = 0;
        repeat (3) step();
        rst = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check_val("rst_a_out_valid", 64'(ov_a), 64'd0);
        check_val("rst_a_out_data",  64'(od_a), 64'd0);
        check_val("rst_a_in_ready",  64'(ir_a), 64'd1);
        check_val("rst_b_out_valid", 64'(ov_b), 64'd0);
        check_val("rst_b_out_ctrl",  64'(oc_b), 64'd0);
        check_val("rst_b_in_ready",  64'(ir_b), 64'd1);
        check_val("rst_b_bubble",    64'(bc_b), 64'd0);

        // ---- 1: single pass, SKID=0 ----
        step();
        iv_a = 1; id_a = 32'hDEADBEEF; ic_a = 17'h1_0005; ordy_a = 1;
        step();
        iv_a = 0;
        @(negedge clk);
        check_val("t1_out_valid", 64'(ov_a), 64'd1);
        check_val("t1_out_data",  64'(od_a), 64'hDEADBEEF);
        check_val("t1_out_ctrl",  64'(oc_a), 64'h1_0005);
        step();
        @(negedge clk);
        check_val("t1_out_valid_after", 64'(ov_a), 64'd0);
        check_val("t1_out_ctrl_after",  64'(oc_a), 64'd0);
        check_val("t1_bubble",          64'(bc_a), 64'd1);
        ordy_a = 0;

        // ---- 1b: out-transfer completes during flush, SKID=0 ----
        step();
        iv_a = 1; id_a = 32'hA5A5_0001; ic_a = 17'h3;
        step();
        iv_a = 0; fl_a = 1; ordy_a = 1;
        @(negedge clk);
        check_val("t1b_in_ready_flush", 64'(ir_a), 64'd0);
        check_val("t1b_out_valid",      64'(ov_a), 64'd1);
        step();
        fl_a = 0; ordy_a = 0;
        @(negedge clk);
        check_val("t1b_out_valid_after", 64'(ov_a), 64'd0);

        // ---- 2: backpressure fill, SKID=1 ----
        step();
        iv_b = 1; id_b = 32'h11; ic_b = 17'h1;
        step();
        id_b = 32'h22; ic_b = 17'h2;
        step();
        iv_b = 0; ordy_b = 1;
        @(negedge clk);
        check_val("t2_in_ready_full", 64'(ir_b), 64'd0);
        check_val("t2_head_data",     64'(od_b), 64'h11);
        step();
        @(negedge clk);
        check_val("t2_in_ready_after", 64'(ir_b), 64'd1);
        check_val("t2_second_valid",   64'(ov_b), 64'd1);
        check_val("t2_second_data",    64'(od_b), 64'h22);
        step();
        ordy_b = 0;
        @(negedge clk);
        check_val("t2_empty", 64'(ov_b), 64'd0);

        // ---- 3: flush with two entries held ----
        step();
        iv_b = 1; id_b = 32'h44; ic_b = 17'h4;
        step();
        id_b = 32'h55; ic_b = 17'h5;
        step();
        fl_b = 1; id_b = 32'h33; ic_b = 17'h3;
        @(negedge clk);
        check_val("t3_in_ready_flush", 64'(ir_b), 64'd0);
        step();
        fl_b = 0; iv_b = 0;
        @(negedge clk);
        check_val("t3_out_valid", 64'(ov_b), 64'd0);
        check_val("t3_out_ctrl",  64'(oc_b), 64'd0);
        check_val("t3_in_ready",  64'(ir_b), 64'd1);
        ordy_b = 1;
        repeat (2) step();
        @(negedge clk);
        check_val("t3_nothing_left", 64'(ov_b), 64'd0);
        ordy_b = 0;

        // ---- 4: streaming, SKID=1 (after a fresh reset) ----
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        gaps = 0;
        pops0 = pops_b;
        iv_b = 1; ordy_b = 1;
        for (int k = 0; k < 100; k++) begin
            id_b = 32'h1000 + 32'(k);
            ic_b = 17'(k + 1);
            @(negedge clk);
            if (k > 0 && !ov_b) gaps++;
            step();
        end
        iv_b = 0;
        @(negedge clk);
        if (!ov_b) gaps++;
        step();
        ordy_b = 0;
        @(negedge clk);
        check_val("t4_gaps",   64'(gaps), 64'd0);
        check_val("t4_count",  64'(pops_b - pops0), 64'd100);
        check_val("t4_bubble", 64'(bc_b), 64'd1);
        check_val("t4_drained", 64'(ov_b), 64'd0);

        // ---- 5: bubble saturation, CNTW=4 ----
        ordy_b = 1;
        repeat (20) step();
        @(negedge clk);
        check_val("t5_bubble_sat", 64'(bc_b), 64'd15);
        repeat (3) step();
        @(negedge clk);
        check_val("t5_bubble_held", 64'(bc_b), 64'd15);
        ordy_b = 0;

        // ---- 6: asynchronous reset with entries held ----
        step();
        iv_b = 1; id_b = 32'h66; ic_b = 17'h6;
        iv_a = 1; id_a = 32'h77; ic_a = 17'h7;
        step();
        id_b = 32'h67;
        iv_a = 0;
        step();
        iv_b = 0;
        @(negedge clk);
        check_val("t6_b_full", 64'(ir_b), 64'd0);
        check_val("t6_a_held", 64'(ov_a), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_b_out_valid", 64'(ov_b), 64'd0);
        check_val("t6_b_bubble",    64'(bc_b), 64'd0);
        check_val("t6_b_in_ready",  64'(ir_b), 64'd1);
        check_val("t6_a_out_valid", 64'(ov_a), 64'd0);
        check_val("t6_a_bubble",    64'(bc_a), 64'd0);
        check_val("t6_a_out_ctrl",  64'(oc_a), 64'd0);
        step();
        rst = 1'b0;
        ordy_a = 1; ordy_b = 1;
        repeat (2) step();
        @(negedge clk);
        check_val("t6_b_stays_empty", 64'(ov_b), 64'd0);
        check_val("t6_a_stays_empty", 64'(ov_a), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_latch_stage.md
Name: pipe_latch_stage

Overview:
Parametrised pipeline-register stage replacing the fixed-format inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a data payload and a control-bit field across one stage boundary, and uses a valid/ready handshake in place of a single global hit-enable. It adds:
- optional 1-entry skid buffer, so upstream ready is registered;
- flush that kills in-flight entries and zeroes control;
- saturating bubble counter for performance visibility.

Parameters:
DW, 32, payload width in bits (rdat1/rdat2/npc/imm packed by the instantiating stage).
CW, 17, control width in bits (WB/MEM/EX control fields); zeroed on flush/reset.
SKID, 1, 1 = 2-entry (main + skid) registered-ready mode; 0 = single register with combinational ready.
CNTW, 16, width of bubble_cnt.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream entry present.
in_ready  output  1  stage can accept this cycle.
in_data  input  DW  upstream payload.
in_ctrl  input  CW  upstream control bits.
flush  input  1  kill all entries held in this stage (branch/jump mispredict).
out_valid  output  1  out_data/out_ctrl hold a live entry.
out_ready  input  1  downstream accepts.
out_data  output  DW  payload to next stage.
out_ctrl  output  CW  control to next stage; all-zero whenever out_valid=0.
bubble_cnt  output  CNTW  count of downstream-starved cycles.

Behaviour:
- Reset (RST=1, asynchronous, any cycle, including mid-transfer):
  - out_valid=0, out_ctrl=0, out_data=0, skid entry invalid/zero, bubble_cnt=0.
  - in_ready=1 in the first cycle after RST deasserts.
- Transfer rules:
  - in-transfer = in_valid & in_ready.
  - out-transfer = out_valid & out_ready.
  - Data is never duplicated or dropped except by flush/RST.
- SKID=0:
  - in_ready = (!out_valid | out_ready) & !flush, combinational.
  - On in-transfer, the main register loads in_data/in_ctrl and out_valid=1 next cycle.
  - On an out-transfer without an in-transfer, out_valid=0 next cycle.
  - Latency is 1 cycle.
- SKID=1:
  - in_ready = !skid_valid & !flush; skid_valid is a flop, so ready has no combinational path from out_ready.
  - If an in-transfer occurs while main is valid and not draining, the entry goes to the skid register (skid_valid=1).
  - When main drains and skid is valid, skid moves to main the next cycle and skid_valid=0.
  - A simultaneous drain of main and in-transfer with skid empty loads main directly.
  - Order is strictly FIFO; maximum occupancy is 2; latency is 1 cycle when empty.
- Flush (synchronous, one cycle):
  - Next cycle: out_valid=0, skid_valid=0, out_ctrl=0, skid ctrl=0. Data registers hold their values (do not care).
  - in_ready=0 during the flush cycle, so no in-transfer occurs.
  - An out-transfer in the flush cycle still completes: the downstream consumer sees the current entry.
  - Flush with RST: RST dominates.
- out_ctrl is forced 0 whenever out_valid=0, so downstream decode sees a NOP bubble.
- bubble_cnt:
  - +1 on every cycle with out_ready=1 & out_valid=0.
  - Saturates at 2^CNTW-1 and never wraps.
  - Cleared only by RST.
- Full boundary (SKID=1, both entries valid): in_ready=0; upstream must hold in_valid/in_data stable.
- Empty boundary: out_valid=0; out_ready is ignored except for bubble counting.

Test Plan:
1. Reset and single pass, SKID=0: apply RST; then in_valid=1, in_data=0xDEADBEEF, in_ctrl=0x1_0005, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0xDEADBEEF, out_ctrl=0x10005; following cycle out_valid=0, out_ctrl=0.
2. Backpressure fill, SKID=1: out_ready=0; push 0x11, 0x22 -> in_ready=0 after the 2nd push. Then out_ready=1 -> outputs 0x11 then 0x22 in consecutive cycles; in_ready=1 the cycle after 0x11 drains.
3. Flush with 2 entries held: flush=1 for 1 cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1. A push of 0x33 during the flush cycle is not accepted (in_ready=0).
4. Streaming, SKID=1: in_valid=1 and out_ready=1 for 100 cycles with incrementing data -> 100 outputs in order with no gaps after 1 cycle of latency; bubble_cnt=1.
5. Bubble saturation, CNTW=4: out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt=15, held.
6. Mid-operation reset: assert RST asynchronously between edges with 2 entries held -> out_valid=0 and bubble_cnt=0 immediately, without waiting for a clock edge.
